frame_uart_tx: RTL and testbench

Parametrised framed UART transmitter, the successor of the fixed 1024-byte lidar frame sender. It buffers payload bytes in an internal single-clock FIFO, counts committed frames, and, while enabled, emits each frame over 8N1 UART as `{(` + zero-padded decimal length + payload + `)}`. It sits between the frame assembler (write side) and the host serial link (`tx` pin).

---
 rtl/frame_uart_tx.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_frame_uart_tx.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_uart_tx.sv
// ---------------------------------------------------------------------------
// frame_uart_tx
//
// Framed UART transmitter. Payload bytes are buffered in an internal FIFO.
// Each frame_mark pulse commits one frame. While send_en is high, every
// committed frame is sent over 8N1 UART as:
//   '{' '(' <LEN_DIGITS zero-padded decimal PAYLOAD_LEN> <payload> ')' '}'
// With FRAME_UART_TX_CHKSUM_EN defined, one extra byte follows the payload.
// That byte is the XOR of all payload bytes of the frame.
//
// Ports:
//   clk            system clock, the only clock
//   rst            synchronous reset, active high
//   wr_data        payload byte to buffer
//   wr_en          write strobe, one byte per cycle
//   frame_mark     one-cycle pulse: one complete frame now sits in the FIFO
//   send_en        level; a new frame starts only while this is high
//   tx             UART line, idles high
//   wr_full        FIFO full
//   wr_level       FIFO occupancy in bytes
//   frames_pending committed frames that have not been sent yet
//   busy           high from the first start bit until the last stop bit ends
//   ovf            sticky; set by a write while full or by a mark at the limit
// ---------------------------------------------------------------------------
module frame_uart_tx #(
    parameter int CLK_HZ      = 50000000,
    parameter int BAUD        = 115200,
    parameter int PAYLOAD_LEN = 1024,
    parameter int LEN_DIGITS  = 4,
    parameter int FIFO_DEPTH  = 2048,
    parameter int MAX_PENDING = 7
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [7:0]                         wr_data,
    input  logic                               wr_en,
    input  logic                               frame_mark,
    input  logic                               send_en,
    output logic                               tx,
    output logic                               wr_full,
    output logic [$clog2(FIFO_DEPTH):0]        wr_level,
    output logic [$clog2(MAX_PENDING+1)-1:0]   frames_pending,
    output logic                               busy,
    output logic                               ovf
);

    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int CW      = $clog2(BIT_CYC);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int LW      = AW + 1;
    localparam int PW      = $clog2(MAX_PENDING + 1);
    localparam int HDR_LEN = 2 + LEN_DIGITS;
    localparam int IDX_MAX = (PAYLOAD_LEN > HDR_LEN) ? PAYLOAD_LEN : HDR_LEN;
    localparam int IW      = $clog2(IDX_MAX);

    // Header bytes packed so that byte i is sent i-th. The digits are found
    // at elaboration, so no divider is built in hardware.
    function automatic logic [8*HDR_LEN-1:0] hdr_init();
        logic [8*HDR_LEN-1:0] r;
        int v;
        r        = '0;
        r[7:0]   = 8'h7B;
        r[15:8]  = 8'h28;
        v        = PAYLOAD_LEN;
        for (int i = LEN_DIGITS - 1; i >= 0; i--) begin
            r[8*(2+i) +: 8] = 8'h30 + 8'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    localparam logic [8*HDR_LEN-1:0] HDR = hdr_init();

`ifdef FRAME_UART_TX_CHKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HEAD, S_DATA, S_SUM, S_TAIL} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_HEAD, S_DATA, S_TAIL} state_t;
`endif

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [LW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   pending_q, pending_d;
    logic            ovf_q, ovf_d;
    logic            tx_q, tx_d;
    logic            active_q, active_d;
    logic [3:0]      bit_q, bit_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [8:0]      shreg_q, shreg_d;
`ifdef FRAME_UART_TX_CHKSUM_EN
    logic [7:0]      chk_q, chk_d;
`endif
    logic [7:0]      mem [FIFO_DEPTH];

    logic [LW-1:0]   level;
    logic            fifo_empty, push, pop_en, load_en, byte_done, eng_ready;
    logic            start_frame;
    logic [7:0]      rd_byte, hdr_byte, load_byte;

    assign level       = wr_ptr_q - rd_ptr_q;
    assign fifo_empty  = (level == '0);
    assign wr_full     = (level == LW'(FIFO_DEPTH));
    assign push        = wr_en && !wr_full;
    assign rd_byte     = mem[rd_ptr_q[AW-1:0]];
    // The last cycle of a stop bit is where the next byte gets loaded, so
    // consecutive bytes go out with no idle gap between them.
    assign byte_done   = active_q && (bit_q == 4'd9) && (cyc_q == CW'(BIT_CYC - 1));
    assign eng_ready   = !active_q || byte_done;
    assign start_frame = (state_q == S_IDLE) && send_en && (pending_q != '0) && !active_q;

    always_comb begin
        hdr_byte = 8'h00;
        for (int i = 0; i < HDR_LEN; i++) begin
            if (idx_q == IW'(i)) hdr_byte = HDR[8*i +: 8];
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // FSM: next state. Here idx counts the next byte to load in the section.
    always_comb begin
        // NOTE: Every combinational output gets a default first. No path is
        // left unassigned, so no latch is inferred.
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: if (start_frame) begin
                state_d = S_HEAD;
                idx_d   = IW'(1);
            end
            S_HEAD: if (load_en) begin
                if (idx_q == IW'(HDR_LEN - 1)) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DATA: if (load_en) begin
                if (idx_q == IW'(PAYLOAD_LEN - 1)) begin
`ifdef FRAME_UART_TX_CHKSUM_EN
                    state_d = S_SUM;
`else
                    state_d = S_TAIL;
`endif
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
`ifdef FRAME_UART_TX_CHKSUM_EN
            S_SUM: if (load_en) begin
                state_d = S_TAIL;
                idx_d   = '0;
            end
`endif
            S_TAIL: if (load_en) begin
                if (idx_q == IW'(1)) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs. These say which byte goes to the serialiser, and when.
    always_comb begin
        load_en   = 1'b0;
        load_byte = 8'h00;
        pop_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                load_en   = start_frame;
                load_byte = 8'h7B;
            end
            S_HEAD: begin
                load_en   = eng_ready;
                load_byte = hdr_byte;
            end
            S_DATA: begin
                // An empty FIFO stalls the frame and the line stays idle high.
                load_en   = eng_ready && !fifo_empty;
                pop_en    = load_en;
                load_byte = rd_byte;
            end
`ifdef FRAME_UART_TX_CHKSUM_EN
            S_SUM: begin
                load_en   = eng_ready;
                load_byte = chk_q;
            end
`endif
            S_TAIL: begin
                load_en   = eng_ready;
                load_byte = (idx_q == '0) ? 8'h29 : 8'h7D;
            end
            default: ;
        endcase
    end

    // Datapath: serialiser, FIFO pointers, pending counter, sticky overflow
    always_comb begin
        tx_d      = tx_q;
        active_d  = active_q;
        bit_d     = bit_q;
        cyc_d     = cyc_q;
        shreg_d   = shreg_q;
        wr_ptr_d  = wr_ptr_q + LW'(push);
        rd_ptr_d  = rd_ptr_q + LW'(pop_en);
        pending_d = pending_q;
        ovf_d     = ovf_q || (wr_en && wr_full);

        if (load_en) begin
            tx_d     = 1'b0;
            active_d = 1'b1;
            bit_d    = 4'd0;
            cyc_d    = '0;
            shreg_d  = {1'b1, load_byte};
        end else if (active_q) begin
            if (cyc_q == CW'(BIT_CYC - 1)) begin
                cyc_d = '0;
                if (bit_q == 4'd9) begin
                    active_d = 1'b0;
                    tx_d     = 1'b1;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    tx_d    = shreg_q[0];
                    shreg_d = {1'b1, shreg_q[8:1]};
                end
            end else begin
                cyc_d = cyc_q + CW'(1);
            end
        end

        // A mark in the same cycle as a frame start cancels the decrement.
        if (start_frame && !frame_mark) begin
            pending_d = pending_q - PW'(1);
        end else if (frame_mark && !start_frame) begin
            if (pending_q == PW'(MAX_PENDING)) ovf_d = 1'b1;
            else pending_d = pending_q + PW'(1);
        end
    end

`ifdef FRAME_UART_TX_CHKSUM_EN
    always_comb begin
        chk_d = chk_q;
        if (start_frame) chk_d = 8'h00;
        else if (pop_en) chk_d = chk_q ^ rd_byte;
    end
`endif

    always_ff @(posedge clk) begin
        // NOTE: Sequential state uses non-blocking assignments only. All
        // flops then update together and do not depend on statement order.
        if (rst) begin
            tx_q      <= 1'b1;
            active_q  <= 1'b0;
            bit_q     <= 4'd0;
            cyc_q     <= '0;
            shreg_q   <= '1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pending_q <= '0;
            ovf_q     <= 1'b0;
`ifdef FRAME_UART_TX_CHKSUM_EN
            chk_q     <= 8'h00;
`endif
        end else begin
            tx_q      <= tx_d;
            active_q  <= active_d;
            bit_q     <= bit_d;
            cyc_q     <= cyc_d;
            shreg_q   <= shreg_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
`ifdef FRAME_UART_TX_CHKSUM_EN
            chk_q     <= chk_d;
`endif
        end
    end

    // NOTE: The storage array has no reset. Resetting the pointers flushes
    // the FIFO, and the array can then map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    assign tx             = tx_q;
    assign wr_level       = level;
    assign frames_pending = pending_q;
    assign busy           = active_q || (state_q != S_IDLE);
    assign ovf            = ovf_q;

endmodule

// File: tb/tb_frame_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_frame_uart_tx
//
// Bench for frame_uart_tx with a 4-cycle bit time, a 4-byte payload and an
// 8-byte FIFO. A table of payloads is sent through the transmitter, and the
// line is decoded and compared with hand-computed frames. Short directed
// sequences cover the cases that span many cycles: an empty-FIFO stall,
// send_en dropping mid-frame, both overflows, and reset in the middle of a
// frame.
// ---------------------------------------------------------------------------
module tb_frame_uart_tx;

    localparam int BYTE_CYC = 40;
`ifdef FRAME_UART_TX_CHKSUM_EN
    localparam int NB = 13;
`else
    localparam int NB = 12;
`endif
    localparam int FRAME_CYC = NB * BYTE_CYC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en = 1'b0;
    logic       frame_mark = 1'b0;
    logic       send_en = 1'b0;
    logic       tx, wr_full, busy, ovf;
    logic [3:0] wr_level;
    logic [2:0] frames_pending;

    frame_uart_tx #(
        .CLK_HZ(400), .BAUD(100), .PAYLOAD_LEN(4), .LEN_DIGITS(4),
        .FIFO_DEPTH(8), .MAX_PENDING(7)
    ) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en),
        .frame_mark(frame_mark), .send_en(send_en), .tx(tx),
        .wr_full(wr_full), .wr_level(wr_level),
        .frames_pending(frames_pending), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] pay;   // payload byte i sits in pay[8*i +: 8]
        logic [7:0]  chk;   // hand-computed XOR of the payload
        int          cyc;   // expected frame length in cycles
    } vec_t;

    vec_t       vecs [3];
    logic [7:0] exp_bytes [NB];
    int         errors = 0;
    int         checks = 0;
    int         last_start = 0;
    logic       busy_lost;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        wr_data = b;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic mark();
        frame_mark = 1'b1;
        tick();
        frame_mark = 1'b0;
    endtask

    // Expected frame without the checksum. Callers add it when it is built in.
    task automatic fill_exp(input logic [31:0] pay);
        exp_bytes[0] = 8'h7B;
        exp_bytes[1] = 8'h28;
        exp_bytes[2] = 8'h30;
        exp_bytes[3] = 8'h30;
        exp_bytes[4] = 8'h30;
        exp_bytes[5] = 8'h34;
        for (int i = 0; i < 4; i++) exp_bytes[6+i] = pay[8*i +: 8];
        exp_bytes[NB-2] = 8'h29;
        exp_bytes[NB-1] = 8'h7D;
    endtask

    // Decode one UART byte starting from the current sample, with a bounded
    // wait for the start bit. Bits are sampled mid-bit (4-cycle bit time).
    task automatic rx_byte(input string name, input logic [7:0] expv, input bit chk_gap);
        int         waited = 0;
        logic [7:0] b;
        logic       stop;
        while (tx !== 1'b0 && waited < 400) begin
            tick();
            waited++;
        end
        if (tx !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL %s: no start bit within 400 cycles", name);
            return;
        end
        if (chk_gap) check({name, " gap"}, cyc_cnt - last_start, BYTE_CYC);
        last_start = cyc_cnt;
        if (busy !== 1'b1) busy_lost = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 8; i++) begin
            repeat (4) tick();
            b[i] = tx;
            if (busy !== 1'b1) busy_lost = 1'b1;
        end
        repeat (4) tick();
        stop = tx;
        check(name, {23'd0, stop, b}, {23'd0, 1'b1, expv});
    endtask

    task automatic rx_range(input string name, input int first, input int last, input bit gap_first);
        for (int i = first; i <= last; i++)
            rx_byte($sformatf("%s byte%0d", name, i), exp_bytes[i], (i != first) || gap_first);
    endtask

    task automatic wait_idle(input string name, output int fall);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL %s: busy still high after 200 cycles", name);
        end
        fall = cyc_cnt;
    endtask

    task automatic quiet(input string name, input int n, input logic exp_busy);
        logic bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== exp_busy) bad = 1'b1;
        end
        check({name, " line idle"}, {31'd0, bad}, 32'd0);
    endtask

    initial begin
        int en_cyc, first_start, fall;

        vecs[0] = '{pay: 32'h04030201, chk: 8'h04, cyc: FRAME_CYC};
        vecs[1] = '{pay: 32'h5AA500FF, chk: 8'h00, cyc: FRAME_CYC};
        vecs[2] = '{pay: 32'h137E4180, chk: 8'hAC, cyc: FRAME_CYC};

        // Reset state
        do_reset();
        check("reset tx", tx, 1);
        check("reset busy", busy, 0);
        check("reset wr_full", wr_full, 0);
        check("reset wr_level", wr_level, 0);
        check("reset pending", frames_pending, 0);
        check("reset ovf", ovf, 0);

        // Table-driven frames
        for (int v = 0; v < 3; v++) begin
            fill_exp(vecs[v].pay);
`ifdef FRAME_UART_TX_CHKSUM_EN
            exp_bytes[10] = vecs[v].chk;
`endif
            for (int i = 0; i < 4; i++) wr_byte(vecs[v].pay[8*i +: 8]);
            check($sformatf("v%0d wr_level", v), wr_level, 4);
            mark();
            check($sformatf("v%0d pending after mark", v), frames_pending, 1);
            busy_lost = 1'b0;
            send_en   = 1'b1;
            en_cyc    = cyc_cnt;
            rx_range($sformatf("v%0d", v), 0, 0, 1'b0);
            first_start = last_start;
            check($sformatf("v%0d start latency", v), first_start - en_cyc, 1);
            check($sformatf("v%0d pending after start", v), frames_pending, 0);
            send_en = 1'b0;
            rx_range($sformatf("v%0d", v), 1, NB - 1, 1'b1);
            wait_idle($sformatf("v%0d", v), fall);
            check($sformatf("v%0d frame cycles", v), fall - first_start, vecs[v].cyc);
            check($sformatf("v%0d busy held", v), {31'd0, busy_lost}, 0);
            check($sformatf("v%0d wr_level end", v), wr_level, 0);
        end

        // Empty-FIFO stall in DATA, then a push and a pop in the same cycle
        fill_exp(32'h44332211);
`ifdef FRAME_UART_TX_CHKSUM_EN
        exp_bytes[10] = 8'h44;
`endif
        wr_byte(8'h11);
        wr_byte(8'h22);
        mark();
        busy_lost = 1'b0;
        send_en   = 1'b1;
        rx_range("stall", 0, 7, 1'b0);
        send_en = 1'b0;
        quiet("stall hold", 20, 1'b1);
        wr_data = 8'h33;
        wr_en   = 1'b1;
        tick();
        check("stall level after push", wr_level, 1);
        wr_data = 8'h44;
        tick();
        wr_en = 1'b0;
        check("push+pop level", wr_level, 1);
        check("stall resume tx", tx, 0);
        rx_range("stall", 8, NB - 1, 1'b0);
        wait_idle("stall", fall);
        check("stall busy held", {31'd0, busy_lost}, 0);

        // send_en falls mid-frame with two frames pending
        fill_exp(32'h40302010);
`ifdef FRAME_UART_TX_CHKSUM_EN
        exp_bytes[10] = 8'h40;
`endif
        for (int i = 0; i < 4; i++) wr_byte(8'h10 * (i + 1));
        wr_byte(8'hC3);
        wr_byte(8'h5A);
        wr_byte(8'h0F);
        wr_byte(8'hF0);
        check("drop wr_full", wr_full, 1);
        mark();
        mark();
        check("drop pending 2", frames_pending, 2);
        send_en = 1'b1;
        rx_range("drop", 0, 6, 1'b0);
        send_en = 1'b0;
        check("drop pending 1", frames_pending, 1);
        rx_range("drop", 7, NB - 1, 1'b1);
        wait_idle("drop", fall);
        quiet("drop no restart", 60, 1'b0);
        check("drop pending still 1", frames_pending, 1);

        // Mark in the same cycle as the frame start leaves the count unchanged
        fill_exp(32'hF00F5AC3);
`ifdef FRAME_UART_TX_CHKSUM_EN
        exp_bytes[10] = 8'h66;
`endif
        frame_mark = 1'b1;
        send_en    = 1'b1;
        tick();
        frame_mark = 1'b0;
        check("mark+start pending", frames_pending, 1);
        rx_range("frame2", 0, 0, 1'b0);
        send_en = 1'b0;
        rx_range("frame2", 1, NB - 1, 1'b1);
        wait_idle("frame2", fall);

        // FIFO overflow
        do_reset();
        for (int i = 0; i < 8; i++) wr_byte(8'(i));
        check("fifo full level", wr_level, 8);
        check("fifo full flag", wr_full, 1);
        check("fifo ovf before", ovf, 0);
        wr_byte(8'hEE);
        check("fifo ovf level", wr_level, 8);
        check("fifo ovf set", ovf, 1);
        do_reset();
        check("ovf cleared by rst", ovf, 0);

        // Pending-counter saturation
        for (int i = 0; i < 7; i++) mark();
        check("pending at max", frames_pending, 7);
        check("pending ovf before", ovf, 0);
        mark();
        check("pending saturated", frames_pending, 7);
        check("pending ovf set", ovf, 1);

        // Reset in the middle of DATA
        fill_exp(32'hDDCCBBAA);
        for (int i = 0; i < 4; i++) wr_byte(8'hAA + 8'(17 * i));
        send_en = 1'b1;
        rx_range("rstmid", 0, 5, 1'b0);
        repeat (10) tick();
        check("rstmid busy before", busy, 1);
        check("rstmid level before", wr_level, 3);
        rst = 1'b1;
        tick();
        check("rstmid tx", tx, 1);
        check("rstmid busy", busy, 0);
        check("rstmid wr_level", wr_level, 0);
        check("rstmid pending", frames_pending, 0);
        check("rstmid ovf", ovf, 0);
        rst = 1'b0;
        quiet("rstmid after", 60, 1'b0);
        send_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
